// File: rtl/move_sequencer_if.sv
// Host-side move stream into the move sequencer: 4-bit face-turn code with a
// valid/ready handshake. The host drives as master, the sequencer acts as slave.
interface move_sequencer_if;
  logic [3:0] move_in;
  logic       move_in_valid;
  logic       move_in_ready;

  modport master (
    output move_in,
    output move_in_valid,
    input  move_in_ready
  );

  modport slave (
    input  move_in,
    input  move_in_valid,
    output move_in_ready
  );
endinterface

// File: rtl/move_sequencer.sv
// Buffers face-turn codes and issues them one at a time to the stepper executor
// over the move_start / move_done handshake. Optional MOVE_SEQ_CANCEL_EN folds a
// move followed by its inverse out of the queue.
module move_sequencer #(
  parameter int DEPTH         = 64,
  parameter int ADDR_W        = 6,
  parameter int START_TIMEOUT = 16,
  parameter int ISSUE_GAP     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  move_sequencer_if.slave    host,
  input  logic               run,
  input  logic               flush,
  input  logic               move_done,
  output logic [3:0]         next_move,
  output logic               move_start,
  output logic               busy,
  output logic [ADDR_W:0]    queue_count,
  output logic [15:0]        moves_completed,
  output logic               seq_done,
  output logic               timeout_err
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    GAP
  } state_t;

  logic [3:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]     r_count;

  state_t            r_state;
  logic [3:0]        r_next_move;
  logic              r_move_start;
  logic              r_seq_done;
  logic              r_timeout_err;
  logic [15:0]       r_moves_completed;
  logic [15:0]       r_tmo_cnt;
  logic [15:0]       r_gap_cnt;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_cancel;
  logic              w_inc;
  logic [3:0]        w_head;
  logic              w_head_ok;
  state_t            w_after_move;
  logic              w_skip_gap;

  // Full is the MSB of the count because DEPTH == 2**ADDR_W.
  assign w_ready   = !r_count[ADDR_W] && !flush;
  assign w_push    = host.move_in_valid && w_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_ok = (w_head >= 4'd2) && (w_head <= 4'd13);
  assign w_pop     = (r_state == IDLE) && run && (r_count != '0) && move_done && !flush;

`ifdef MOVE_SEQ_CANCEL_EN
  logic [3:0] w_tail;
  assign w_tail   = r_mem[r_wr_ptr - ADDR_W'(1)];
  // A lone entry that is leaving as the head this cycle cannot be cancelled.
  assign w_cancel = w_push && (r_count != '0) && (host.move_in == (w_tail ^ 4'd1)) &&
                    !(w_pop && (r_count == CW'(1)));
`else
  assign w_cancel = 1'b0;
`endif

  assign w_inc = w_push && !w_cancel;

  always_ff @(posedge clock) begin
    if (w_inc) begin
      r_mem[r_wr_ptr] <= host.move_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_cancel) begin
        r_wr_ptr <= r_wr_ptr - ADDR_W'(1);
      end else if (w_inc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count <= r_count + CW'(w_inc) - CW'(w_cancel) - CW'(w_pop);
    end
  end

  // With no gap configured the FSM returns straight to IDLE after a move.
  assign w_skip_gap   = (ISSUE_GAP == 0);
  assign w_after_move = w_skip_gap ? IDLE : GAP;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= IDLE;
      r_next_move       <= '0;
      r_move_start      <= 1'b0;
      r_seq_done        <= 1'b0;
      r_timeout_err     <= 1'b0;
      r_moves_completed <= '0;
      r_tmo_cnt         <= '0;
      r_gap_cnt         <= '0;
    end else begin
      r_move_start <= 1'b0;
      r_seq_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop && w_head_ok) begin
            r_next_move  <= w_head;
            r_move_start <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!move_done) begin
            r_state <= WAIT_HIGH;
          end else if (r_tmo_cnt == 16'(START_TIMEOUT - 1)) begin
            r_timeout_err     <= 1'b1;
            r_moves_completed <= r_moves_completed + 16'd1;
            r_gap_cnt         <= '0;
            r_seq_done        <= w_skip_gap && (r_count == '0);
            r_state           <= w_after_move;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (move_done) begin
            r_moves_completed <= r_moves_completed + 16'd1;
            r_gap_cnt         <= '0;
            r_seq_done        <= w_skip_gap && (r_count == '0);
            r_state           <= w_after_move;
          end
        end
        GAP: begin
          if (r_gap_cnt == 16'(ISSUE_GAP - 1)) begin
            r_seq_done <= (r_count == '0);
            r_state    <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign host.move_in_ready = w_ready;
  assign next_move          = r_next_move;
  assign move_start         = r_move_start;
  assign busy               = (r_state != IDLE);
  assign queue_count        = r_count;
  assign moves_completed    = r_moves_completed;
  assign seq_done           = r_seq_done;
  assign timeout_err        = r_timeout_err;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: issued codes are queued on push and
// compared when move_start fires; an executor model answers the handshake.
module tb_move_sequencer;
  localparam int ISSUE_GAP = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic        move_done = 1'b1;
  logic [3:0]  next_move;
  logic        move_start;
  logic        busy;
  logic [6:0]  queue_count;
  logic [15:0] moves_completed;
  logic        seq_done;
  logic        timeout_err;

  move_sequencer_if host_if();

  move_sequencer #(
    .DEPTH(64),
    .ADDR_W(6),
    .START_TIMEOUT(16),
    .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .host(host_if.slave),
    .run(run),
    .flush(flush),
    .move_done(move_done),
    .next_move(next_move),
    .move_start(move_start),
    .busy(busy),
    .queue_count(queue_count),
    .moves_completed(moves_completed),
    .seq_done(seq_done),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_push   = 0;
  int t_start  = 0;
  int t_rise   = -1;
  int n_start  = 0;
  int n_seq    = 0;
  logic [3:0] sb [$];

  bit   exec_en   = 1'b1;
  bit   skip_hold = 1'b0;
  int   low_dly   = 3;
  int   high_dly  = 51;
  logic [3:0] exec_code;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Issue monitor: scoreboard order, inter-move gap and seq_done emptiness.
  initial forever begin
    @(negedge clock);
    if (move_start === 1'b1) begin
      n_start++;
      t_start = cyc;
      expect_eq("issue_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) expect_eq("issue_code", next_move, sb.pop_front());
      if (t_rise >= 0) expect_eq("issue_gap", 32'((cyc - t_rise) >= (1 + ISSUE_GAP)), 1);
    end
    if (seq_done === 1'b1) begin
      n_seq++;
      expect_eq("seq_done_queue_empty", queue_count, 0);
    end
  end

  // Executor model: drops move_done low_dly cycles after a start, raises it high_dly later.
  initial forever begin
    @(negedge clock);
    if (exec_en && move_start === 1'b1) begin
      exec_code = next_move;
      repeat (low_dly) @(negedge clock);
      move_done = 1'b0;
      repeat (high_dly) @(negedge clock);
      if (!skip_hold) expect_eq("next_move_hold", next_move, exec_code);
      move_done = 1'b1;
      t_rise = cyc;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic push_move(input logic [3:0] code, output bit acc);
    @(negedge clock);
    host_if.move_in       = code;
    host_if.move_in_valid = 1'b1;
    #1 acc = host_if.move_in_ready;
    if (acc) begin
      t_push = cyc;
`ifdef MOVE_SEQ_CANCEL_EN
      // Cancellation is only modelled with the queue stalled (run low).
      if (!run && sb.size() != 0 && code == (sb[$] ^ 4'd1)) void'(sb.pop_back());
      else if (code >= 4'd2 && code <= 4'd13) sb.push_back(code);
`else
      if (code >= 4'd2 && code <= 4'd13) sb.push_back(code);
`endif
    end
    @(posedge clock);
    #1 host_if.move_in_valid = 1'b0;
  endtask

  task automatic wait_seq(input string tag, input int target);
    for (int i = 0; i < 3000; i++) begin
      if (n_seq >= target) break;
      @(negedge clock);
      #2;
    end
    expect_eq(tag, n_seq, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_eq({tag, "_next_move"}, next_move, 0);
    expect_eq({tag, "_move_start"}, move_start, 0);
    expect_eq({tag, "_busy"}, busy, 0);
    expect_eq({tag, "_queue_count"}, queue_count, 0);
    expect_eq({tag, "_moves_completed"}, moves_completed, 0);
    expect_eq({tag, "_seq_done"}, seq_done, 0);
    expect_eq({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    bit acc;
    int seq0;
    int start0;
    host_if.move_in       = '0;
    host_if.move_in_valid = 1'b0;

    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    #1 expect_eq("ready_after_reset", host_if.move_in_ready, 1);

    // Single move R with a slow executor.
    run = 1'b1;
    push_move(4'd2, acc);
    wait_seq("t1_seq_done", 1);
    expect_eq("t1_start_latency", t_start - t_push, 2);
    expect_eq("t1_moves_completed", moves_completed, 1);
    expect_eq("t1_busy", busy, 0);
    expect_eq("t1_timeout_err", timeout_err, 0);

    // U, Ui, F back to back.
    low_dly  = 2;
    high_dly = 10;
    start0 = n_start;
    push_move(4'd4, acc);
    push_move(4'd5, acc);
    push_move(4'd6, acc);
    wait_seq("t2_seq_done", 2);
    expect_eq("t2_issues", n_start - start0, 3);
    expect_eq("t2_moves_completed", moves_completed, 4);

    // Illegal code 0 is discarded, D issues once.
    start0 = n_start;
    push_move(4'd0, acc);
    push_move(4'd12, acc);
    wait_seq("t3_seq_done", 3);
    expect_eq("t3_issues", n_start - start0, 1);
    expect_eq("t3_moves_completed", moves_completed, 5);

    // Disabled executor: start timeout.
    exec_en = 1'b0;
    push_move(4'd2, acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #2;
      if (timeout_err === 1'b1) break;
    end
    expect_eq("t4_timeout_err", timeout_err, 1);
    expect_eq("t4_timeout_latency", cyc - t_start, 17);
    wait_seq("t4_seq_done", 4);
    expect_eq("t4_moves_completed", moves_completed, 6);
    expect_eq("t4_busy", busy, 0);
    exec_en = 1'b1;

    // Fill with run low, refuse at full, then flush.
    run = 1'b0;
    for (int unsigned i = 0; i < 64; i++) push_move(4'((i % 12) + 2), acc);
    expect_eq("t5_fill_count", queue_count, sb.size());
    expect_eq("t5_full_count", queue_count, 64);
    expect_eq("t5_full_ready", host_if.move_in_ready, 0);
    push_move(4'd3, acc);
    expect_eq("t5_push_refused", acc, 0);
    expect_eq("t5_count_after_refuse", queue_count, 64);
    @(negedge clock);
    flush = 1'b1;
    #1 expect_eq("t5_ready_during_flush", host_if.move_in_ready, 0);
    @(posedge clock);
    #1 flush = 1'b0;
    expect_eq("t5_count_after_flush", queue_count, 0);
    sb.delete();

    // Asynchronous reset in the middle of WAIT_HIGH.
    run       = 1'b1;
    skip_hold = 1'b1;
    high_dly  = 30;
    push_move(4'd7, acc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      #2;
      if (move_done === 1'b0) break;
    end
    expect_eq("t6_executor_busy", move_done, 0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("t6_async");
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      #2;
      if (move_done === 1'b1) break;
    end
    @(negedge clock);
    reset_n = 1'b1;
    start0 = n_start;
    repeat (20) @(negedge clock);
    expect_eq("t6_no_reissue", n_start - start0, 0);
    expect_eq("t6_busy", busy, 0);
    skip_hold = 1'b0;

`ifdef MOVE_SEQ_CANCEL_EN
    // L then Li cancel; B, B, Bi leaves a single B.
    run  = 1'b0;
    seq0 = n_seq;
    push_move(4'd8, acc);
    push_move(4'd9, acc);
    expect_eq("t7_cancel_pair", queue_count, 0);
    push_move(4'd10, acc);
    push_move(4'd10, acc);
    push_move(4'd11, acc);
    expect_eq("t7_cancel_tail", queue_count, 1);
    expect_eq("t7_model_count", queue_count, sb.size());
    run = 1'b1;
    wait_seq("t7_seq_done", seq0 + 1);
`else
    seq0 = n_seq;
    push_move(4'd13, acc);
    wait_seq("t7_seq_done", seq0 + 1);
`endif
    expect_eq("final_scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
